// File: rtl/wrr_arbiter_n.sv
// Weighted round-robin pop arbiter with a one-hot push to the destination one cycle after each pop.
// Registered pop with no input-to-pop comb path; any almost_full stalls pops and keeps ptr/credit.
module wrr_arbiter_n #(
    parameter int NUM_CH   = 4,
    parameter int DEST_W   = 2,
    parameter int WEIGHT_W = 3
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic [NUM_CH*WEIGHT_W-1:0] weights,
    input  logic [NUM_CH-1:0]          empty,
    input  logic [NUM_CH-1:0]          almost_empty,
    input  logic [NUM_CH-1:0]          almost_full,
    input  logic [DEST_W-1:0]          dest,
    output logic [NUM_CH-1:0]          pop,
    output logic [NUM_CH-1:0]          push,
    output logic [DEST_W-1:0]          active_ch,
    output logic                       idle
);
    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    logic [WEIGHT_W-1:0] wt [NUM_CH];
    logic [NUM_CH-1:0]   elig;
    logic [NUM_CH-1:0]   pop_d;
    logic [NUM_CH-1:0]   pop_n;
    logic [DEST_W-1:0]   ptr;
    logic [DEST_W-1:0]   ptr_n;
    logic [DEST_W-1:0]   sel;
    logic [DEST_W-1:0]   cand;
    logic [WEIGHT_W-1:0] credit;
    logic [WEIGHT_W-1:0] credit_n;
    logic                found;

    // A channel being popped on its last word is already empty for the next decision.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wt[i]   = weights[i*WEIGHT_W +: WEIGHT_W];
        assign elig[i] = !empty[i] && !(pop[i] && almost_empty[i]) && (wt[i] != '0);
    end

    // Search starts after ptr and wraps to ptr itself last.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = ptr + DEST_W'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        pop_n    = '0;
        ptr_n    = ptr;
        credit_n = credit;
        if (|almost_full) begin
            pop_n = '0;
        end else if (elig[ptr] && (credit != '0)) begin
            pop_n    = ONE << ptr;
            credit_n = credit - 1'b1;
        end else if (found) begin
            pop_n    = ONE << sel;
            ptr_n    = sel;
            credit_n = wt[sel] - 1'b1;
        end else begin
            credit_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            pop       <= '0;
            pop_d     <= '0;
            ptr       <= '0;
            credit    <= '0;
            active_ch <= '0;
            idle      <= 1'b1;
        end else begin
            pop       <= pop_n;
            pop_d     <= pop;
            ptr       <= ptr_n;
            credit    <= credit_n;
            active_ch <= ptr_n;
            idle      <= (pop_n == '0);
        end
    end

    assign push = (pop_d != '0) ? (ONE << dest) : '0;

endmodule

// File: tb/tb_wrr_arbiter_n.sv
// Bench for wrr_arbiter_n: source FIFOs modelled as queues, arbitration predicted per cycle.
module tb_wrr_arbiter_n;
    localparam int N  = 4;
    localparam int DW = 2;
    localparam int WW = 3;

    logic            clk = 1'b0;
    logic            reset_L;
    logic [N*WW-1:0] weights;
    logic [N-1:0]    empty;
    logic [N-1:0]    almost_empty;
    logic [N-1:0]    almost_full;
    logic [DW-1:0]   dest;
    logic [N-1:0]    pop;
    logic [N-1:0]    push;
    logic [DW-1:0]   active_ch;
    logic            idle;

    wrr_arbiter_n #(.NUM_CH(N), .DEST_W(DW), .WEIGHT_W(WW)) dut (
        .clk(clk), .reset_L(reset_L), .weights(weights), .empty(empty),
        .almost_empty(almost_empty), .almost_full(almost_full), .dest(dest),
        .pop(pop), .push(push), .active_ch(active_ch), .idle(idle)
    );

    always #5 clk = ~clk;

    int            checks;
    int            errors;
    logic [DW-1:0] fq [N][$];
    int            m_cur;
    int            m_left;
    logic [N-1:0]  exp_pop;
    logic [N-1:0]  exp_push;
    logic          exp_idle;
    logic [DW-1:0] exp_act;
    logic [DW-1:0] held;

    function automatic int wt(input int i);
        return int'(weights[i*WW +: WW]);
    endfunction

    function automatic bit avail(input int i);
        return (fq[i].size() > 0) && (wt(i) != 0);
    endfunction

    task automatic fill(input int ch, input int n, input int d);
        for (int k = 0; k < n; k++)
            fq[ch].push_back(d < 0 ? DW'($urandom_range(N - 1, 0)) : DW'(d));
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) fq[i].delete();
    endtask

    // Drive flags for this cycle, predict the next edge, then move to the next negedge.
    task automatic advance();
        logic [N-1:0] np;
        bit           had_pop;
        bit           found;
        int           j;
        for (int i = 0; i < N; i++) begin
            empty[i]        = (fq[i].size() == 0);
            almost_empty[i] = (fq[i].size() == 1);
        end
        had_pop = (exp_pop != 0) && (reset_L === 1'b1);
        for (int i = 0; i < N; i++)
            if (exp_pop[i] && fq[i].size() > 0) held = fq[i].pop_front();
        np = '0;
        if (reset_L !== 1'b1) begin
            m_cur  = 0;
            m_left = 0;
        end else if (almost_full != 0) begin
            np = '0;
        end else if (avail(m_cur) && m_left > 0) begin
            np[m_cur] = 1'b1;
            m_left--;
        end else begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                j = (m_cur + k) % N;
                if (!found && avail(j)) begin
                    found  = 1;
                    m_cur  = j;
                    m_left = wt(j) - 1;
                    np[j]  = 1'b1;
                end
            end
            if (!found) m_left = 0;
        end
        exp_pop  = np;
        exp_idle = (np == 0);
        exp_act  = DW'(m_cur);
        exp_push = had_pop ? (N'(1) << held) : '0;
        @(negedge clk);
        dest = held;
        #1;
    endtask

    task automatic do_reset();
        reset_L     = 1'b0;
        almost_full = '0;
        advance();
        advance();
    endtask

    task automatic test_reset();
        weights     = {3'd1, 3'd2, 3'd3, 3'd4};
        almost_full = '0;
        clear_all();
        for (int i = 0; i < N; i++) fill(i, 8, i);
        reset_L = 1'b0;
        for (int c = 0; c < 3; c++) begin
            advance();
            checks += 4;
            if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop cyc=%0d got=%b exp=0000", c, pop); end
            if (push !== 4'b0000) begin errors++; $display("FAIL reset_push cyc=%0d got=%b exp=0000", c, push); end
            if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=1", c, idle); end
            if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active cyc=%0d got=%0d exp=0", c, active_ch); end
        end
        for (int i = 1; i < N; i++) fq[i].delete();
        reset_L = 1'b1;
        advance();
        checks += 3;
        if (pop !== 4'b0001) begin errors++; $display("FAIL release_pop got=%b exp=0001", pop); end
        if (pop !== exp_pop) begin errors++; $display("FAIL release_model got=%b exp=%b", pop, exp_pop); end
        if (idle !== 1'b0) begin errors++; $display("FAIL release_idle got=%b exp=0", idle); end
    endtask

    task automatic test_weighted();
        int cnt [N];
        do_reset();
        clear_all();
        for (int i = 0; i < N; i++) begin fill(i, 40, 0); cnt[i] = 0; end
        weights = {3'd1, 3'd2, 3'd3, 3'd4};
        reset_L = 1'b1;
        for (int c = 0; c < 20; c++) begin
            advance();
            checks += 2;
            if (pop !== exp_pop) begin errors++; $display("FAIL wrr_pop cyc=%0d got=%b exp=%b", c, pop, exp_pop); end
            if (push !== exp_push) begin errors++; $display("FAIL wrr_push cyc=%0d got=%b exp=%b", c, push, exp_push); end
            for (int i = 0; i < N; i++) cnt[i] += int'(pop[i]);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (cnt[i] != 2 * wt(i)) begin errors++; $display("FAIL wrr_share ch=%0d got=%0d exp=%0d", i, cnt[i], 2 * wt(i)); end
        end
    endtask

    task automatic test_skip_empty();
        int c0;
        int c3;
        c0 = 0;
        c3 = 0;
        do_reset();
        clear_all();
        fill(0, 40, 1);
        fill(3, 40, 2);
        weights = {3'd1, 3'd2, 3'd3, 3'd4};
        reset_L = 1'b1;
        for (int c = 0; c < 15; c++) begin
            advance();
            checks += 2;
            if (pop !== exp_pop) begin errors++; $display("FAIL skip_pop cyc=%0d got=%b exp=%b", c, pop, exp_pop); end
            if (idle !== 1'b0) begin errors++; $display("FAIL skip_bubble cyc=%0d got=%b exp=0", c, idle); end
            c0 += int'(pop[0]);
            c3 += int'(pop[3]);
        end
        checks++;
        if (c0 != 12 || c3 != 3) begin errors++; $display("FAIL skip_share got=%0d/%0d exp=12/3", c0, c3); end
    endtask

    task automatic test_short_burst();
        logic [N-1:0] seq [3];
        seq[0] = 4'b0001;
        seq[1] = 4'b0001;
        seq[2] = 4'b0010;
        do_reset();
        clear_all();
        fill(0, 2, 1);
        weights = {3'd1, 3'd2, 3'd3, 3'd4};
        reset_L = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance();
            if (c == 0) fill(1, 10, 3);
            checks += 2;
            if (pop !== seq[c]) begin errors++; $display("FAIL short_pop cyc=%0d got=%b exp=%b", c, pop, seq[c]); end
            if (pop !== exp_pop) begin errors++; $display("FAIL short_model cyc=%0d got=%b exp=%b", c, pop, exp_pop); end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] ep [7];
        logic [N-1:0] eq [7];
        logic [N-1:0] af [7];
        ep = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
        eq = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        af = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        do_reset();
        clear_all();
        fill(1, 20, 2);
        fill(2, 20, 0);
        weights = {3'd1, 3'd2, 3'd3, 3'd4};
        reset_L = 1'b1;
        for (int c = 0; c < 7; c++) begin
            almost_full = af[c];
            advance();
            checks += 4;
            if (pop !== ep[c]) begin errors++; $display("FAIL bp_pop cyc=%0d got=%b exp=%b", c, pop, ep[c]); end
            if (push !== eq[c]) begin errors++; $display("FAIL bp_push cyc=%0d got=%b exp=%b", c, push, eq[c]); end
            if (pop !== exp_pop) begin errors++; $display("FAIL bp_model cyc=%0d got=%b exp=%b", c, pop, exp_pop); end
            if (idle !== (ep[c] == 0)) begin errors++; $display("FAIL bp_idle cyc=%0d got=%b exp=%b", c, idle, ep[c] == 0); end
        end
        almost_full = '0;
    endtask

    task automatic test_disabled();
        do_reset();
        clear_all();
        fill(1, 10, 0);
        weights = {3'd1, 3'd2, 3'd0, 3'd4};
        reset_L = 1'b1;
        for (int c = 0; c < 4; c++) begin
            advance();
            checks += 2;
            if (pop !== 4'b0000) begin errors++; $display("FAIL dis_pop cyc=%0d got=%b exp=0000", c, pop); end
            if (idle !== 1'b1) begin errors++; $display("FAIL dis_idle cyc=%0d got=%b exp=1", c, idle); end
        end
        weights[1*WW +: WW] = 3'd2;
        for (int c = 0; c < 3; c++) begin
            advance();
            checks += 2;
            if (pop !== 4'b0010) begin errors++; $display("FAIL en_pop cyc=%0d got=%b exp=0010", c, pop); end
            if (active_ch !== 2'd1) begin errors++; $display("FAIL en_active cyc=%0d got=%0d exp=1", c, active_ch); end
        end
    endtask

    task automatic test_random();
        do_reset();
        clear_all();
        weights = N*WW'($urandom);
        reset_L = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39, 0) == 0) weights[$urandom_range(N - 1, 0)*WW +: WW] = WW'($urandom);
            for (int i = 0; i < N; i++)
                if ($urandom_range(3, 0) == 0 && fq[i].size() < 5) fill(i, 1, -1);
            almost_full = ($urandom_range(9, 0) == 0) ? N'($urandom_range(15, 1)) : '0;
            reset_L     = ($urandom_range(199, 0) != 0);
            advance();
            checks += 4;
            if (pop !== exp_pop) begin errors++; $display("FAIL rand_pop cyc=%0d got=%b exp=%b", c, pop, exp_pop); end
            if (push !== exp_push) begin errors++; $display("FAIL rand_push cyc=%0d got=%b exp=%b", c, push, exp_push); end
            if (idle !== exp_idle) begin errors++; $display("FAIL rand_idle cyc=%0d got=%b exp=%b", c, idle, exp_idle); end
            if (active_ch !== exp_act) begin errors++; $display("FAIL rand_active cyc=%0d got=%0d exp=%0d", c, active_ch, exp_act); end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_L      = 1'b0;
        weights      = '0;
        almost_full  = '0;
        empty        = '1;
        almost_empty = '0;
        dest         = '0;
        exp_pop      = '0;
        exp_push     = '0;
        exp_idle     = 1'b1;
        exp_act      = '0;
        held         = '0;
        m_cur        = 0;
        m_left       = 0;
        test_reset();
        test_weighted();
        test_skip_empty();
        test_short_burst();
        test_backpressure();
        test_disabled();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wrr_arbiter_n.md
Name: wrr_arbiter_n

Overview:
- Parametrised weighted round-robin arbiter between NUM_CH transmit FIFOs and NUM_CH receive FIFOs in the PCIe datapath.
- Each cycle it selects at most one source FIFO to pop, drawing up to its programmable weight of consecutive words before rotating, and skipping empty or zero-weight channels with no bubble cycle.
- The popped word's destination field drives a one-hot push to the matching receive FIFO on the following cycle.
- Any receive almost_full stalls all pops without losing arbitration state.

Parameters:
- NUM_CH, 4, number of source and destination FIFOs (power of two, 2..16).
- DEST_W, 2, width of the dest field; equals log2(NUM_CH).
- WEIGHT_W, 3, width of each per-channel weight field.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  synchronous reset, active-low.
- weights  input  NUM_CH*WEIGHT_W  per-channel weight; channel i at bits [i*WEIGHT_W +: WEIGHT_W]; 0 means channel disabled.
- empty  input  NUM_CH  source FIFO empty flags.
- almost_empty  input  NUM_CH  source FIFO one-word-left flags.
- almost_full  input  NUM_CH  destination FIFO almost-full flags.
- dest  input  DEST_W  destination field of the word currently at the popped FIFO's output; valid when pop_d is nonzero.
- pop  output  NUM_CH  registered one-hot pop, or zero.
- push  output  NUM_CH  one-hot push to destination FIFO, or zero.
- active_ch  output  DEST_W  registered index of the channel currently holding the grant.
- idle  output  1  registered; 1 when no pop was issued this cycle.

Behaviour:
- Reset (reset_L=0 at a clk edge):
  - pop=0, push=0, pop_d=0, ptr=0, credit=0, active_ch=0, idle=1.
  - Reset mid-burst abandons remaining credit.
  - A push that was due in the next cycle is suppressed.
- Eligibility, computed combinationally each cycle: elig[i] = !empty[i] && !(pop[i] && almost_empty[i]) && weights[i]!=0.
  - The almost_empty term covers the one-cycle flag lag after the last-word pop.
- Stall: if |almost_full, then pop<=0 and idle<=1. ptr and credit hold their values.
- Otherwise, continue the current grant: if elig[ptr] && credit!=0, then pop<=onehot(ptr) and credit<=credit-1.
- Otherwise, rotate:
  - Search j = ptr+1, ptr+2, …, ptr (mod NUM_CH, ptr checked last) for the first elig[j].
  - If found: pop<=onehot(j), ptr<=j, credit<=weights[j]-1. The weight is sampled only at this switch cycle.
  - If none found: pop<=0, idle<=1, credit<=0, ptr held.
- Burst length: a channel receives at most weights[i] consecutive pops per turn. Fewer if it empties first; rotation then happens on the next cycle with no idle gap.
- Weight changes take effect at the next grant switch; an in-progress burst is unaffected.
- active_ch<=ptr (the new value after any switch). idle<=(pop==0 next).
- Push path:
  - pop_d<=pop on every edge.
  - push = (pop_d!=0) ? onehot(dest) : 0, combinational from the registered pop_d and dest.
  - Push therefore trails the corresponding pop by exactly 1 cycle, aligned with the source FIFO's registered read data.
  - A push is still issued for a word popped in the cycle before almost_full rose. Destination FIFOs must reserve ≥1 word of slack beyond almost_full.
- All empty, or all weights zero: pop stays 0 and push stays 0 one cycle later.
- Single eligible channel: the search wraps to ptr itself and refills credit, so that channel is popped every cycle.
- No combinational path from any input to pop. push depends combinationally only on dest.

Test Plan:
- Reset: hold reset_L=0 3 cycles with empty=0 and weights nonzero -> pop=0, push=0, idle=1, active_ch=0; first release cycle pops ch0 (ptr=0 checked last after ch1..3 are empty).
- Weighted rotation: weights={1,2,3,4} (ch3..ch0), all FIFOs deep, dest=0 -> pop sequence ch0×4, ch1×3, ch2×2, ch3×1, repeating; push=0001 each cycle starting 1 cycle after the first pop.
- Skip empty: empty=4'b0110, weights 4,3,2,1 -> ch0×4 then ch3×1 then ch0×4; no idle cycle at any switch.
- Short burst: ch0 holds 2 words (almost_empty rises after 1st pop), weight 4, ch1 full -> pop ch0, ch0, then ch1 the next cycle; no third ch0 pop.
- Backpressure: assert almost_full[2] mid ch1 burst after 1 of 3 pops -> pop=0 while asserted, one trailing push; on release ch1 resumes with 2 remaining pops.
- Disabled and idle: weights[1]=0 with all other channels empty except ch1 -> pop stays 0 and idle=1; later set weights[1]=2 -> ch1 popped on the next cycle.
